// File: rtl/alu_unit.sv
// alu_unit: integer ALU that merges simple and multiply completions onto one
// registered writeback port through a 4-entry FIFO. Optional feature: ALU_MUL_EN.
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif
`ifndef ALU_ADD
`define ALU_ADD    5'd0
`define ALU_SUB    5'd1
`define ALU_AND    5'd2
`define ALU_OR     5'd3
`define ALU_XOR    5'd4
`define ALU_SLL    5'd5
`define ALU_SRL    5'd6
`define ALU_SRA    5'd7
`define ALU_SLT    5'd8
`define ALU_SLTU   5'd9
`define ALU_EQ     5'd10
`define ALU_NE     5'd11
`define ALU_LT     5'd12
`define ALU_GE     5'd13
`define ALU_LTU    5'd14
`define ALU_GEU    5'd15
`define ALU_MUL    5'd16
`define ALU_MULH   5'd17
`define ALU_MULHSU 5'd18
`define ALU_MULHU  5'd19
`endif

module alu_unit (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_clear,
  input  logic                     alu_valid,
  input  logic [31:0]              alu_r1,
  input  logic [31:0]              alu_r2,
  input  logic [`RS_TYPE_BIT-1:0]  alu_op,
  input  logic [`ROB_SIZE_BIT-1:0] alu_rob_idx,
  output logic                     alu_wb_valid,
  output logic [`ROB_SIZE_BIT-1:0] alu_wb_idx,
  output logic [31:0]              alu_wb_value
);
  localparam int IW = `ROB_SIZE_BIT;

  logic          w_accept;
  logic          w_simple_valid;
  logic [31:0]   w_simple_value;
  logic          w_mul_valid;
  logic [IW-1:0] w_mul_idx;
  logic [31:0]   w_mul_value;

  assign w_accept = alu_valid & rdy_in & ~rob_clear & ~rst_in;

  // Simple-op datapath; multiply opcodes fall to the default and yield zero
  always_comb begin
    w_simple_value = 32'd0;
    case (alu_op)
      `ALU_ADD:  w_simple_value = alu_r1 + alu_r2;
      `ALU_SUB:  w_simple_value = alu_r1 - alu_r2;
      `ALU_AND:  w_simple_value = alu_r1 & alu_r2;
      `ALU_OR:   w_simple_value = alu_r1 | alu_r2;
      `ALU_XOR:  w_simple_value = alu_r1 ^ alu_r2;
      `ALU_SLL:  w_simple_value = alu_r1 << alu_r2[4:0];
      `ALU_SRL:  w_simple_value = alu_r1 >> alu_r2[4:0];
      `ALU_SRA:  w_simple_value = $unsigned($signed(alu_r1) >>> alu_r2[4:0]);
      `ALU_SLT, `ALU_LT:   w_simple_value = {31'd0, $signed(alu_r1) < $signed(alu_r2)};
      `ALU_SLTU, `ALU_LTU: w_simple_value = {31'd0, alu_r1 < alu_r2};
      `ALU_EQ:   w_simple_value = {31'd0, alu_r1 == alu_r2};
      `ALU_NE:   w_simple_value = {31'd0, alu_r1 != alu_r2};
      `ALU_GE:   w_simple_value = {31'd0, $signed(alu_r1) >= $signed(alu_r2)};
      `ALU_GEU:  w_simple_value = {31'd0, alu_r1 >= alu_r2};
      default:   w_simple_value = 32'd0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                w_is_mul;
  logic                r_m1_valid;
  logic [IW-1:0]       r_m1_idx;
  logic                r_m1_hi;
  logic signed [63:0]  r_m1_a;
  logic signed [63:0]  r_m1_b;
  logic signed [63:0]  w_prod;

  assign w_is_mul = (alu_op == `ALU_MUL) | (alu_op == `ALU_MULH) |
                    (alu_op == `ALU_MULHSU) | (alu_op == `ALU_MULHU);
  assign w_simple_valid = w_accept & ~w_is_mul;

  // Stage 1: capture operands extended to 64 bits by per-op signedness
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_m1_valid <= 1'b0;
    end else if (rdy_in) begin
      r_m1_valid <= w_accept & w_is_mul;
      if (w_accept & w_is_mul) begin
        r_m1_idx <= alu_rob_idx;
        r_m1_hi  <= (alu_op != `ALU_MUL);
        r_m1_a   <= {{32{alu_r1[31] & ((alu_op == `ALU_MULH) | (alu_op == `ALU_MULHSU))}}, alu_r1};
        r_m1_b   <= {{32{alu_r2[31] & (alu_op == `ALU_MULH)}}, alu_r2};
      end
    end
  end

  // Stage 2: product and half select, consumed directly by the merge logic
  assign w_prod      = r_m1_a * r_m1_b;
  assign w_mul_valid = r_m1_valid;
  assign w_mul_idx   = r_m1_idx;
  assign w_mul_value = r_m1_hi ? w_prod[63:32] : w_prod[31:0];
`else
  assign w_simple_valid = w_accept;
  assign w_mul_valid    = 1'b0;
  assign w_mul_idx      = {IW{1'b0}};
  assign w_mul_value    = 32'd0;
`endif

  logic [IW-1:0] r_fifo_idx [4];
  logic [31:0]   r_fifo_val [4];
  logic [1:0]    r_rptr;
  logic [1:0]    r_wptr;
  logic [2:0]    r_count;
  logic          w_sel_valid;
  logic [IW-1:0] w_sel_idx;
  logic [31:0]   w_sel_value;
  logic          w_pop;
  logic          w_push_mul;
  logic          w_push_simple;
  logic [1:0]    w_push_cnt;
  logic [3:0]    w_count_next;

  // Output source priority: FIFO head, then multiply, then simple; losers are queued
  always_comb begin
    w_sel_valid   = 1'b0;
    w_sel_idx     = {IW{1'b0}};
    w_sel_value   = 32'd0;
    w_pop         = 1'b0;
    w_push_mul    = 1'b0;
    w_push_simple = 1'b0;
    if (r_count != 3'd0) begin
      w_sel_valid   = 1'b1;
      w_sel_idx     = r_fifo_idx[r_rptr];
      w_sel_value   = r_fifo_val[r_rptr];
      w_pop         = 1'b1;
      w_push_mul    = w_mul_valid;
      w_push_simple = w_simple_valid;
    end else if (w_mul_valid) begin
      w_sel_valid   = 1'b1;
      w_sel_idx     = w_mul_idx;
      w_sel_value   = w_mul_value;
      w_push_simple = w_simple_valid;
    end else if (w_simple_valid) begin
      w_sel_valid   = 1'b1;
      w_sel_idx     = alu_rob_idx;
      w_sel_value   = w_simple_value;
    end else begin
      w_sel_valid   = 1'b0;
    end
  end

  assign w_push_cnt   = {1'b0, w_push_mul} + {1'b0, w_push_simple};
  assign w_count_next = {1'b0, r_count} + {2'd0, w_push_cnt} - {3'd0, w_pop};

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rptr  <= 2'd0;
      r_wptr  <= 2'd0;
      r_count <= 3'd0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        r_rptr  <= 2'd0;
        r_wptr  <= 2'd0;
        r_count <= 3'd0;
      end else begin
        r_rptr  <= r_rptr + {1'b0, w_pop};
        r_wptr  <= r_wptr + w_push_cnt;
        r_count <= w_count_next[2:0];
      end
    end
  end

  // FIFO storage; a simple result lands behind a multiply result pushed the same cycle
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rob_clear && !rst_in) begin
      if (w_push_mul) begin
        r_fifo_idx[r_wptr] <= w_mul_idx;
        r_fifo_val[r_wptr] <= w_mul_value;
      end
      if (w_push_simple) begin
        r_fifo_idx[w_push_mul ? r_wptr + 2'd1 : r_wptr] <= alu_rob_idx;
        r_fifo_val[w_push_mul ? r_wptr + 2'd1 : r_wptr] <= w_simple_value;
      end
    end
  end

`ifndef SYNTHESIS
  // Occupancy must never exceed the four physical entries
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !rob_clear) begin
      assert (w_count_next <= 4'd4) else $error("alu_unit result FIFO overflow");
    end
  end
`endif

  // Registered writeback port
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      alu_wb_valid <= 1'b0;
      alu_wb_idx   <= {IW{1'b0}};
      alu_wb_value <= 32'd0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        alu_wb_valid <= 1'b0;
      end else begin
        alu_wb_valid <= w_sel_valid;
        if (w_sel_valid) begin
          alu_wb_idx   <= w_sel_idx;
          alu_wb_value <= w_sel_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit with hand-computed results.
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif
`ifndef ALU_ADD
`define ALU_ADD    5'd0
`define ALU_SUB    5'd1
`define ALU_AND    5'd2
`define ALU_OR     5'd3
`define ALU_XOR    5'd4
`define ALU_SLL    5'd5
`define ALU_SRL    5'd6
`define ALU_SRA    5'd7
`define ALU_SLT    5'd8
`define ALU_SLTU   5'd9
`define ALU_EQ     5'd10
`define ALU_NE     5'd11
`define ALU_LT     5'd12
`define ALU_GE     5'd13
`define ALU_LTU    5'd14
`define ALU_GEU    5'd15
`define ALU_MUL    5'd16
`define ALU_MULH   5'd17
`define ALU_MULHSU 5'd18
`define ALU_MULHU  5'd19
`endif

module tb_alu_unit;
  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     rdy_in;
  logic                     rob_clear;
  logic                     alu_valid;
  logic [31:0]              alu_r1;
  logic [31:0]              alu_r2;
  logic [`RS_TYPE_BIT-1:0]  alu_op;
  logic [`ROB_SIZE_BIT-1:0] alu_rob_idx;
  logic                     alu_wb_valid;
  logic [`ROB_SIZE_BIT-1:0] alu_wb_idx;
  logic [31:0]              alu_wb_value;

  int checks_s   = 0;
  int failures_s = 0;

  alu_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .alu_valid(alu_valid), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_op(alu_op),
    .alu_rob_idx(alu_rob_idx), .alu_wb_valid(alu_wb_valid),
    .alu_wb_idx(alu_wb_idx), .alu_wb_value(alu_wb_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_s++;
    if (got !== exp) begin
      failures_s++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] idx);
    alu_valid   = 1'b1;
    alu_op      = op;
    alu_r1      = a;
    alu_r2      = b;
    alu_rob_idx = idx;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input logic [3:0] idx, input logic [31:0] val);
    check_eq({tag, ".valid"}, {31'd0, alu_wb_valid}, 32'd1);
    check_eq({tag, ".idx"},   {28'd0, alu_wb_idx}, {28'd0, idx});
    check_eq({tag, ".value"}, alu_wb_value, val);
  endtask

  task automatic expect_none(input string tag);
    check_eq({tag, ".valid"}, {31'd0, alu_wb_valid}, 32'd0);
  endtask

  logic [4:0]  v_op  [15];
  logic [31:0] v_a   [15];
  logic [31:0] v_b   [15];
  logic [31:0] v_exp [15];

  initial begin
    v_op  = '{`ALU_SUB, `ALU_AND, `ALU_OR, `ALU_XOR, `ALU_SLL, `ALU_SRL, `ALU_SLT, `ALU_SLTU,
              `ALU_EQ, `ALU_NE, `ALU_LT, `ALU_LTU, `ALU_GEU, `ALU_ADD, `ALU_SRA};
    v_a   = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1, 32'h80000000,
              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'h80000000, 32'h80000000,
              32'd0, 32'hFFFFFFFF, 32'h40000000};
    v_b   = '{32'd7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'd33, 32'd31,
              32'd1, 32'd1, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd2, 32'd30};
    v_exp = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'd2, 32'd1,
              32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd1, 32'd1};

    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
    alu_valid = 1'b0; alu_r1 = 32'd0; alu_r2 = 32'd0; alu_op = `ALU_ADD; alu_rob_idx = 4'd0;
    tick(); tick();
    check_eq("reset.valid", {31'd0, alu_wb_valid}, 32'd0);
    check_eq("reset.idx",   {28'd0, alu_wb_idx}, 32'd0);
    check_eq("reset.value", alu_wb_value, 32'd0);
    rst_in = 1'b0;

    // single ADD, visible for exactly one cycle
    issue(`ALU_ADD, 32'd7, 32'd5, 4'd3); tick();
    expect_wb("add", 4'd3, 32'd12);
    idle(); tick();
    expect_none("add.after");

    // back-to-back SRA / SLTU / GE
    issue(`ALU_SRA, 32'h80000000, 32'd4, 4'd1); tick();
    expect_wb("b2b.sra", 4'd1, 32'hF8000000);
    issue(`ALU_SLTU, 32'd1, 32'hFFFFFFFF, 4'd2); tick();
    expect_wb("b2b.sltu", 4'd2, 32'd1);
    issue(`ALU_GE, 32'hFFFFFFFF, 32'd0, 4'd4); tick();
    expect_wb("b2b.ge", 4'd4, 32'd0);
    idle(); tick();
    expect_none("b2b.after");

    // operation table issued back-to-back
    for (int i = 0; i < 15; i++) begin
      issue(v_op[i], v_a[i], v_b[i], 4'(i));
      tick();
      expect_wb($sformatf("vec%0d", i), 4'(i), v_exp[i]);
    end
    idle(); tick();
    expect_none("vec.after");

    // flush drops an issue in the same cycle and kills a pending writeback
    rob_clear = 1'b1; issue(`ALU_ADD, 32'd1, 32'd2, 4'd8); tick();
    expect_none("clr.same");
    rob_clear = 1'b0; idle(); tick();
    expect_none("clr.same2");
    issue(`ALU_ADD, 32'd3, 32'd4, 4'd9); tick();
    expect_wb("clr.pre", 4'd9, 32'd7);
    rob_clear = 1'b1; idle(); tick();
    expect_none("clr.out");
    rob_clear = 1'b0;

    // ready low holds the output and ignores issues, then advances once
    issue(`ALU_SUB, 32'd9, 32'd2, 4'd2); tick();
    expect_wb("rdy.pre", 4'd2, 32'd7);
    rdy_in = 1'b0; issue(`ALU_ADD, 32'd1, 32'd1, 4'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_wb($sformatf("rdy.hold%0d", i), 4'd2, 32'd7);
    end
    rdy_in = 1'b1; issue(`ALU_ADD, 32'd1, 32'd3, 4'd4); tick();
    expect_wb("rdy.adv", 4'd4, 32'd4);
    idle(); tick();
    expect_none("rdy.after");

    // reset with ready low mid-operation
    issue(`ALU_OR, 32'h12, 32'h21, 4'd6); tick();
    expect_wb("rst.pre", 4'd6, 32'h33);
    rdy_in = 1'b0; rst_in = 1'b1; idle(); tick();
    check_eq("rst.mid.valid", {31'd0, alu_wb_valid}, 32'd0);
    check_eq("rst.mid.idx",   {28'd0, alu_wb_idx}, 32'd0);
    check_eq("rst.mid.value", alu_wb_value, 32'd0);
    rdy_in = 1'b1; rst_in = 1'b0; tick();

`ifdef ALU_MUL_EN
    // MUL then ADD: multiply first, ADD drained from the FIFO
    issue(`ALU_MUL, 32'd6, 32'd7, 4'd5); tick();
    expect_none("mul.c1");
    issue(`ALU_ADD, 32'd1, 32'd1, 4'd6); tick();
    expect_wb("mul.c2", 4'd5, 32'd42);
    idle(); tick();
    expect_wb("mul.c3", 4'd6, 32'd2);
    tick();
    expect_none("mul.c4");
    check_eq("mul.count", {29'd0, dut.r_count}, 32'd0);

    // high-half variants on identical operands
    issue(`ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1); tick();
    expect_none("mulh.c1");
    issue(`ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2); tick();
    expect_wb("mulh", 4'd1, 32'd0);
    issue(`ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3); tick();
    expect_wb("mulhsu", 4'd2, 32'hFFFFFFFF);
    issue(`ALU_MUL, 32'hFFFFFFFF, 32'd2, 4'd4); tick();
    expect_wb("mulhu", 4'd3, 32'hFFFFFFFE);
    idle(); tick();
    expect_wb("mul.lo", 4'd4, 32'hFFFFFFFE);
    tick();
    expect_none("mulv.after");

    // interleaved MUL/ADD keeps completion order through the FIFO
    issue(`ALU_MUL, 32'd3, 32'd3, 4'd1); tick();
    issue(`ALU_ADD, 32'd2, 32'd2, 4'd2); tick();
    expect_wb("mix.1", 4'd1, 32'd9);
    issue(`ALU_MUL, 32'd5, 32'd5, 4'd3); tick();
    expect_wb("mix.2", 4'd2, 32'd4);
    issue(`ALU_ADD, 32'd8, 32'd8, 4'd4); tick();
    expect_wb("mix.3", 4'd3, 32'd25);
    idle(); tick();
    expect_wb("mix.4", 4'd4, 32'd16);
    tick();
    expect_none("mix.after");

    // flush one cycle after a MUL issue: its result never appears
    issue(`ALU_MUL, 32'd6, 32'd7, 4'd5); tick();
    rob_clear = 1'b1; idle(); tick();
    expect_none("mulclr.c2");
    rob_clear = 1'b0; tick();
    expect_none("mulclr.c3");
    tick();
    expect_none("mulclr.c4");
    check_eq("mulclr.count", {29'd0, dut.r_count}, 32'd0);
`else
    // without the multiplier, multiply opcodes complete as zero at L=1
    issue(`ALU_MULHU, 32'hFFFFFFFF, 32'd2, 4'd7); tick();
    expect_wb("nomul.mulhu", 4'd7, 32'd0);
    issue(`ALU_MUL, 32'd6, 32'd7, 4'd5); tick();
    expect_wb("nomul.mul", 4'd5, 32'd0);
    idle(); tick();
    expect_none("nomul.after");
    check_eq("nomul.count", {29'd0, dut.r_count}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end
endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 clk_in  input  1  system clock; all state updates on rising edge.
REQ-002 rst_in  input  1  reset; synchronous, active-high.
REQ-003 rdy_in  input  1  global ready; when low, all state holds and outputs stay unchanged.
REQ-004 rob_clear  input  1  misprediction flush; discards all in-flight work.
REQ-005 alu_valid  input  1  issue strobe from reservation station; no backpressure, so the block accepts one issue every cycle.
REQ-006 alu_r1, alu_r2  input  32 each  operands.
REQ-007 alu_op  input  `RS_TYPE_BIT  operation code, using the `ALU_* encodings in config.v.
REQ-008 alu_rob_idx  input  `ROB_SIZE_BIT  destination ROB tag.
REQ-009 alu_wb_valid  output  1  registered writeback strobe, broadcast to RS, LSB and ROB.
REQ-010 alu_wb_idx  output  `ROB_SIZE_BIT  registered writeback tag.
REQ-011 alu_wb_value  output  32  registered writeback value.

Function
REQ-012 An issue is accepted only when alu_valid=1, rdy_in=1, rob_clear=0 and rst_in=0.
REQ-013 Simple ops, computed on 32 bits with wrap-around arithmetic:
- ADD, SUB, AND, OR, XOR.
- SLL, SRL, SRA, with shift amount r2[4:0].
- SLT (signed), SLTU (unsigned).
REQ-014 Compare ops EQ, NE, LT, GE (signed) and LTU, GEU (unsigned) produce 32'd1 if the condition is true, otherwise 32'd0.
REQ-015 Simple-op results enter the completion stage 1 cycle after issue (latency L=1).
REQ-016 Multiply ops exist only per REQ-026 and complete 2 cycles after issue (L=2), through a 2-stage pipeline.
REQ-017 The block SHALL contain a 4-entry circular result FIFO holding (idx, value), with 2-bit read/write pointers and a 3-bit count.
REQ-018 Each cycle the block has up to three result sources, selected for the output register by this priority:
- first, the FIFO head;
- second, the multiply completion;
- third, the simple completion.
REQ-019 Any completion not selected SHALL be pushed into the FIFO in the same cycle, multiply result before simple result, so results leave in completion order with no result lost.
REQ-020 A pop and up to two pushes may happen in the same cycle, and the count updates by pushes minus pops.
REQ-021 alu_wb_valid=1 for exactly one cycle per result.
REQ-022 alu_wb_valid=0 in any cycle with no source available.
REQ-023 FIFO overflow cannot occur under one-issue-per-cycle input; simulation SHALL flag an error if the count would exceed 4.
REQ-024 rob_clear=1 at an edge clears, at that edge:
- the simple stage, both multiply stages and the FIFO (pointers and count to 0);
- alu_wb_valid (to 0).
Any issue presented in that cycle is dropped.
REQ-025 While rdy_in=0:
- no issue is accepted;
- pipeline, FIFO and output registers hold;
- a pending alu_wb_valid=1 stays asserted, unchanged.

Configuration
REQ-026 Macro ALU_MUL_EN:
- When defined: the block implements MUL, MULH (signed x signed), MULHSU (signed x unsigned) and MULHU with the L=2 pipeline, and MUL returns the low 32 bits.
- When undefined: the multiply pipeline is not built; any multiply opcode is treated as a simple op with result 32'd0 and L=1, so the ROB never stalls; only the simple source feeds the output and the FIFO stays empty.

Reset
REQ-027 rst_in=1 at an edge sets:
- alu_wb_valid, alu_wb_idx and alu_wb_value to 0;
- all pipeline valid bits to 0;
- FIFO pointers and count to 0.
Reset takes effect regardless of rdy_in and mid-operation.

Verification
REQ-028 Issue ADD r1=7, r2=5, idx=3 at cycle 0 -> alu_wb_valid=1, idx=3, value=12 at cycle 1 only.
REQ-029 Back-to-back issues on consecutive cycles: SRA 0x80000000 by 4 (idx 1), then SLTU 1 < 0xFFFFFFFF (idx 2), then GE -1 >= 0 (idx 4) -> results 0xF8000000, 1, 0 on three consecutive cycles.
REQ-030 With ALU_MUL_EN defined: MUL 6x7 (idx 5) at cycle 0, then ADD 1+1 (idx 6) at cycle 1 -> idx 5 with value 42 at cycle 2; idx 6 with value 2 at cycle 3, via the FIFO.
REQ-031 rob_clear asserted one cycle after issuing MUL idx 5 -> no writeback for idx 5 ever, and the FIFO count is 0.
REQ-032 rdy_in low for 3 cycles while alu_wb_valid=1 (idx 2) -> output is held for those cycles, then advances exactly once after rdy_in returns high.
REQ-033 Without ALU_MUL_EN: MULHU 0xFFFFFFFF x 2 (idx 7) -> value 0 at cycle 1.
